runway_scheduler: RTL

//  Sequences runway use for Bob: pops plane IDs from the landing and take-off queue FIFOs.

---
 rtl/runway_scheduler_if.sv | 13 +
 rtl/runway_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/runway_scheduler_if.sv
// Clearance channel from the runway scheduler to the reply sender (valid/ready).
interface runway_scheduler_if #(
  parameter int unsigned ID_W = 4
) ();
  logic            clr_valid;
  logic            clr_ready;
  logic [ID_W-1:0] clr_id;
  logic            clr_land;
  logic            clr_rwy;

  modport master (output clr_valid, output clr_id, output clr_land, output clr_rwy, input clr_ready);
  modport slave  (input clr_valid, input clr_id, input clr_land, input clr_rwy, output clr_ready);
endinterface

// File: rtl/runway_scheduler.sv
// Runway scheduler: pops landing/take-off queue heads, assigns a free runway,
// issues clearances and tracks per-runway occupancy until released.
module runway_scheduler #(
  parameter int unsigned MAX_LAND_STREAK = 3,
  parameter int unsigned ID_W            = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                land_pending,
  input  logic [ID_W-1:0]     land_id,
  output logic                land_pop,
  input  logic                tkof_pending,
  input  logic [ID_W-1:0]     tkof_id,
  output logic                tkof_pop,
  input  logic                release_valid,
  input  logic                release_rwy,
  input  logic                emergency_req,
  runway_scheduler_if.master  clr,
  output logic [1:0]          runway_landing,
  output logic [1:0]          runway_takeoff,
  output logic                lockdown
);

  localparam int unsigned STREAK_W = $clog2(MAX_LAND_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, LOCKDOWN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           land_occ_q, land_occ_d;
  logic [1:0]           tkof_occ_q, tkof_occ_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 land_q, land_d;
  logic                 rwy_q, rwy_d;
  logic                 pop_land, pop_tkof;
  logic                 grant_land, grant_rwy;
  logic [1:0]           busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      land_occ_q <= 2'b00;
      tkof_occ_q <= 2'b00;
      streak_q   <= '0;
      id_q       <= '0;
      land_q     <= 1'b0;
      rwy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      land_occ_q <= land_occ_d;
      tkof_occ_q <= tkof_occ_d;
      streak_q   <= streak_d;
      id_q       <= id_d;
      land_q     <= land_d;
      rwy_q      <= rwy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    land_occ_d = land_occ_q;
    tkof_occ_d = tkof_occ_q;
    streak_d   = streak_q;
    id_d       = id_q;
    land_d     = land_q;
    rwy_d      = rwy_q;
    pop_land   = 1'b0;
    pop_tkof   = 1'b0;
    grant_land = 1'b0;
    grant_rwy  = 1'b0;
    busy       = land_occ_q | tkof_occ_q;

    // Release applies first so a grant to the same runway in this cycle still sets it
    if (release_valid) begin
      land_occ_d[release_rwy] = 1'b0;
      tkof_occ_d[release_rwy] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (emergency_req) begin
          state_d = LOCKDOWN;
        end else if (!(&busy) && (land_pending || tkof_pending)) begin
          grant_land = land_pending &&
                       !(tkof_pending && (streak_q == STREAK_W'(MAX_LAND_STREAK)));
          grant_rwy  = busy[0];
          pop_land   = grant_land;
          pop_tkof   = !grant_land;
          id_d       = grant_land ? land_id : tkof_id;
          land_d     = grant_land;
          rwy_d      = grant_rwy;
          state_d    = ISSUE;
          if (grant_land) begin
            land_occ_d[grant_rwy] = 1'b1;
            if (tkof_pending && (streak_q != STREAK_W'(MAX_LAND_STREAK)))
              streak_d = streak_q + STREAK_W'(1);
          end else begin
            tkof_occ_d[grant_rwy] = 1'b1;
            streak_d              = '0;
          end
        end
      end
      ISSUE: begin
        if (clr.clr_ready) state_d = IDLE;
      end
      LOCKDOWN: begin
        if (!emergency_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop strobes are combinational in the grant cycle; held low while in reset
  assign land_pop       = pop_land & reset_n;
  assign tkof_pop       = pop_tkof & reset_n;
  assign clr.clr_valid  = (state_q == ISSUE);
  assign clr.clr_id     = id_q;
  assign clr.clr_land   = land_q;
  assign clr.clr_rwy    = rwy_q;
  assign runway_landing = land_occ_q;
  assign runway_takeoff = tkof_occ_q;
  assign lockdown       = (state_q == LOCKDOWN);

endmodule
